// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - memory-mapped fixed-priority interrupt controller
// Masks level requests, raises irq, latches the acknowledged source ID until EOI.
module interrupt_controller #(
   parameter int               BITS        = 32,
   parameter int               NUM_SRC     = 4,
   parameter logic [BITS-1:0]  IDN_BASE    = 32'hF0000100,
   parameter logic [BITS-1:0]  MASK_BASE   = 32'hF0000104,
   parameter logic [BITS-1:0]  PEND_BASE   = 32'hF0000108,
   parameter logic [BITS-1:0]  EOI_BASE    = 32'hF000010C,
   parameter logic [BITS-1:0]  SPURIOUS_ID = {BITS{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [BITS-1:0]    memAddr,
   input  logic [BITS-1:0]    dataBusIn,
   output logic [BITS-1:0]    dataBusOut,
   input  logic [NUM_SRC-1:0] req,
   input  logic               int_ack,
   output logic               irq,
   output logic               in_service,
   output logic [BITS-1:0]    debug
);

   localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};
   // Writable MASK bits: GIE at the top, one enable per source at the bottom.
   localparam logic [BITS-1:0] MASK_VALID = (ONE << (BITS-1)) | ((ONE << NUM_SRC) - ONE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BITS-1:0]     mask_q, mask_d;
   logic [BITS-1:0]     idn_q, idn_d;

   logic [NUM_SRC-1:0]  pend;
   logic [ID_W-1:0]     win_id;
   logic                none;
   logic                gie;
   logic                mask_wr;
   logic                eoi_wr;
   logic                rd;

   assign pend    = req & mask_q[NUM_SRC-1:0];
   assign none    = ~|pend;
   assign gie     = mask_q[BITS-1];
   assign mask_wr = we && (memAddr == MASK_BASE);
   assign eoi_wr  = we && (memAddr == EOI_BASE);
   assign rd      = re && !we;

   always_comb begin
      win_id = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (pend[i]) win_id = ID_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idn_d   = idn_q;
      if (mask_wr) mask_d = dataBusIn & MASK_VALID;
      case (state_q)
         ST_IDLE: begin
            if (gie && !none) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (int_ack) begin
               state_d = ST_SERVICE;
               idn_d   = none ? SPURIOUS_ID : {{(BITS-ID_W){1'b0}}, win_id};
            end else if (none || !gie) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (eoi_wr) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         idn_q   <= SPURIOUS_ID;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idn_q   <= idn_d;
      end
   end

   assign irq        = (state_q == ST_REQ);
   assign in_service = (state_q == ST_SERVICE);

   always_comb begin
      dataBusOut = '0;
      if (rd) begin
         if (memAddr == IDN_BASE)       dataBusOut = idn_q;
         else if (memAddr == MASK_BASE) dataBusOut = mask_q;
         else if (memAddr == PEND_BASE) dataBusOut = {{(BITS-NUM_SRC){1'b0}}, pend};
      end
   end

   always_comb begin
      debug                = '0;
      debug[BITS-1:BITS-2] = state_q;
      debug[ID_W-1:0]      = win_id;
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

   localparam logic [31:0] IDN  = 32'hF0000100;
   localparam logic [31:0] MASK = 32'hF0000104;
   localparam logic [31:0] PEND = 32'hF0000108;
   localparam logic [31:0] EOI  = 32'hF000010C;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] memAddr = '0;
   logic [31:0] dataBusIn = '0;
   logic [31:0] dataBusOut;
   logic [3:0]  req = '0;
   logic        int_ack = 1'b0;
   logic        irq;
   logic        in_service;
   logic [31:0] debug;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rdata;

   interrupt_controller dut (
      .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
      .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .req(req),
      .int_ack(int_ack), .irq(irq), .in_service(in_service), .debug(debug)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1; memAddr = a; dataBusIn = d;
      tick();
      we = 1'b0; memAddr = '0; dataBusIn = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      re = 1'b1; memAddr = a;
      #1;
      d = dataBusOut;
      re = 1'b0; memAddr = '0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 4'b1111;
      tick(); tick();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b want 0", irq); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_insvc got %0b want 0", in_service); end
      reset = 1'b1;
      tick();
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_idn got %h want ffffffff", rdata); end
      bus_read(MASK, rdata);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", rdata); end
      bus_read(PEND, rdata);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_pend got %h want 0", rdata); end
      n_checks++; if (debug[31:30] !== 2'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_idle got st=%0d irq=%0b want st=0 irq=0", debug[31:30], irq); end
      req = 4'b0000;
   endtask

   task automatic test_bus();
      bus_write(IDN, 32'h0000_0005);
      bus_write(PEND, 32'h0000_000F);
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL idn_ro got %h want ffffffff", rdata); end
      bus_read(32'hF0000110, rdata);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", rdata); end
      we = 1'b1; re = 1'b1; memAddr = IDN; dataBusIn = '0;
      #1;
      n_checks++; if (dataBusOut !== 32'h0) begin n_fail++; $display("FAIL read_during_write got %h want 0", dataBusOut); end
      we = 1'b0; re = 1'b0; memAddr = '0;
   endtask

   task automatic test_priority();
      req = 4'b1010;
      bus_write(MASK, 32'h8000000F);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_old_mask got irq=%0b want 0", irq); end
      tick();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL prio_irq got %0b want 1", irq); end
      n_checks++; if (debug !== 32'h4000_0001) begin n_fail++; $display("FAIL prio_debug got %h want 40000001", debug); end
      bus_read(PEND, rdata);
      n_checks++; if (rdata !== 32'h0000000A) begin n_fail++; $display("FAIL prio_pend got %h want a", rdata); end
      ack();
      n_checks++; if (irq !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL prio_ack got irq=%0b insvc=%0b want 0 1", irq, in_service); end
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL prio_idn got %h want 1", rdata); end
   endtask

   task automatic test_eoi_rearm();
      req = 4'b1000;
      tick();
      n_checks++; if (irq !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL no_preempt got irq=%0b insvc=%0b want 0 1", irq, in_service); end
      bus_write(EOI, 32'h0);
      n_checks++; if (debug[31:30] !== 2'd0 || irq !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL eoi_idle got st=%0d irq=%0b want st=0 irq=0", debug[31:30], irq); end
      tick();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL eoi_rearm got irq=%0b want 1", irq); end
      ack();
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL eoi_idn got %h want 3", rdata); end
      req = 4'b0000;
      bus_write(EOI, 32'hDEAD_BEEF);
      tick();
      n_checks++; if (irq !== 1'b0 || debug[31:30] !== 2'd0) begin n_fail++; $display("FAIL eoi_quiet got irq=%0b st=%0d want 0 0", irq, debug[31:30]); end
   endtask

   task automatic test_mask_gie();
      req = 4'b0001;
      bus_write(MASK, 32'h00000001);
      tick(); tick(); tick();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL gie_off_irq got %0b want 0", irq); end
      bus_read(PEND, rdata);
      n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL gie_off_pend got %h want 1", rdata); end
      bus_write(MASK, 32'h80000001);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL gie_write_edge got %0b want 0", irq); end
      tick();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL gie_on_irq got %0b want 1", irq); end
   endtask

   task automatic test_withdraw_spurious();
      req = 4'b0000;
      tick();
      n_checks++; if (irq !== 1'b0 || debug[31:30] !== 2'd0) begin n_fail++; $display("FAIL withdraw got irq=%0b st=%0d want 0 0", irq, debug[31:30]); end
      req = 4'b0001;
      tick();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL spur_req got irq=%0b want 1", irq); end
      req = 4'b0000;
      ack();
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL spur_svc got %0b want 1", in_service); end
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL spur_idn got %h want ffffffff", rdata); end
      req = 4'b0001;
      ack();
      n_checks++; if (in_service !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL svc_ack_ignored got insvc=%0b irq=%0b want 1 0", in_service, irq); end
      req = 4'b0000;
      bus_write(EOI, 32'h0);
   endtask

   task automatic test_reset_mid_service();
      req = 4'b0100;
      bus_write(MASK, 32'hFFFFFFFF);
      bus_read(MASK, rdata);
      n_checks++; if (rdata !== 32'h8000000F) begin n_fail++; $display("FAIL mask_bits got %h want 8000000f", rdata); end
      tick();
      ack();
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL mid_idn got %h want 2", rdata); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_checks++; if (in_service !== 1'b0 || debug[31:30] !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state got insvc=%0b st=%0d want 0 0", in_service, debug[31:30]); end
      bus_read(MASK, rdata);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mask got %h want 0", rdata); end
      bus_read(IDN, rdata);
      n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mid_rst_idn got %h want ffffffff", rdata); end
      tick(); tick();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq got %0b want 0", irq); end
   endtask

   initial begin
      test_reset();
      test_bus();
      test_priority();
      test_eoi_rearm();
      test_mask_gie();
      test_withdraw_spurious();
      test_reset_mid_service();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
